vx_dispatch_sched: RTL and testbench

VX_DISPATCH_SCHED -- requirements
Module: VX_dispatch_sched

---
 rtl/vx_dispatch_sched.sv | 184 ++++++++++++++++++
 tb/tb_vx_dispatch_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dispatch_sched.sv
// ============================================================================
// Module      : vx_dispatch_sched
// Description : Credit-gated round-robin issue scheduler with a one-entry
//               registered output stage and a flush/drain controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_dispatch_sched #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int NUM_EX   = 5,
    parameter int EX_BITS  = 3,
    parameter int CREDITS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*EX_BITS-1:0]   req_ex_type,
    input  logic [NUM_REQS*DATAW-1:0]     req_data,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          out_valid,
    output logic [EX_BITS-1:0]            out_ex_type,
    output logic [$clog2(NUM_REQS)-1:0]   out_sel,
    output logic [DATAW-1:0]              out_data,
    input  logic                          out_ready,
    input  logic [NUM_EX-1:0]             cmpl_valid,
    output logic [NUM_EX-1:0]             credit_avail,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic                          err
);

    localparam int                 c_SEL_W   = $clog2(NUM_REQS);
    localparam int                 c_CW      = $clog2(CREDITS + 1);
    localparam int                 c_EX_SPAN = 2 ** EX_BITS;
    localparam logic [c_CW-1:0]    c_CREDITS = c_CW'(CREDITS);
    localparam logic [c_CW-1:0]    c_ONE     = c_CW'(1);
    localparam logic [EX_BITS:0]   c_NUM_EX  = (EX_BITS + 1)'(NUM_EX);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_out_valid;
    logic [DATAW-1:0]     r_out_data;
    logic [EX_BITS-1:0]   r_out_ex;
    logic [c_SEL_W-1:0]   r_out_sel;
    logic [c_SEL_W-1:0]   r_last_grant;
    logic                 r_err;

    logic [EX_BITS-1:0]   w_ex_arr   [NUM_REQS];
    logic [DATAW-1:0]     w_data_arr [NUM_REQS];
    logic [NUM_REQS-1:0]  w_elig;
    logic [NUM_REQS-1:0]  w_bad;
    logic [NUM_EX-1:0]    w_avail;
    logic [NUM_EX-1:0]    w_ovf;
    logic [NUM_EX-1:0]    w_full_nxt;
    logic [c_EX_SPAN-1:0] w_avail_pad;
    logic                 w_can_load;
    logic                 w_grant;
    logic                 w_out_valid_nxt;
    logic [c_SEL_W-1:0]   w_pos;
    logic [c_SEL_W-1:0]   w_win;
    logic [EX_BITS-1:0]   w_win_ex;
    logic [DATAW-1:0]     w_win_data;

    assign w_can_load  = !r_out_valid || out_ready;
    assign w_avail_pad = c_EX_SPAN'(w_avail);

    // Eligibility folds in reset so req_ready stays low while reset is asserted.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
        logic w_ex_ok;
        assign w_ex_arr[i]   = req_ex_type[i*EX_BITS +: EX_BITS];
        assign w_data_arr[i] = req_data[i*DATAW +: DATAW];
        assign w_ex_ok       = {1'b0, w_ex_arr[i]} < c_NUM_EX;
        assign w_bad[i]      = req_valid[i] && !w_ex_ok;
        assign w_elig[i]     = req_valid[i] && w_ex_ok && w_avail_pad[w_ex_arr[i]]
                               && reset && (r_state == ST_RUN) && w_can_load;
    end

    always_comb begin
        w_grant    = 1'b0;
        w_pos      = '0;
        w_win      = '0;
        w_win_ex   = '0;
        w_win_data = '0;
        for (int k = 1; k <= NUM_REQS; k++) begin
            w_pos = c_SEL_W'((int'(r_last_grant) + k) % NUM_REQS);
            if (!w_grant && w_elig[w_pos]) begin
                w_grant    = 1'b1;
                w_win      = w_pos;
                w_win_ex   = w_ex_arr[w_pos];
                w_win_data = w_data_arr[w_pos];
            end
        end
    end

    assign req_ready       = w_grant ? (NUM_REQS'(1) << w_win) : '0;
    assign w_out_valid_nxt = w_grant || (r_out_valid && !out_ready);

    for (genvar u = 0; u < NUM_EX; u++) begin : g_credit
        logic            w_dec;
        logic            w_inc;
        logic [c_CW-1:0] w_nxt;
        logic [c_CW-1:0] r_cnt;

        assign w_dec = w_grant && (w_win_ex == EX_BITS'(u));
        assign w_inc = cmpl_valid[u];

        // A completion on a full counter is a protocol error and saturates.
        assign w_ovf[u] = w_inc && !w_dec && (r_cnt == c_CREDITS);

        always_comb begin
            w_nxt = r_cnt;
            if (w_dec && !w_inc) begin
                w_nxt = r_cnt - c_ONE;
            end else if (w_inc && !w_dec && (r_cnt != c_CREDITS)) begin
                w_nxt = r_cnt + c_ONE;
            end
        end

        assign w_full_nxt[u] = (w_nxt == c_CREDITS);
        assign w_avail[u]    = (r_cnt != '0);

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_cnt <= c_CREDITS;
            end else begin
                r_cnt <= w_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ex     <= '0;
            r_out_sel    <= '0;
            r_last_grant <= c_SEL_W'(NUM_REQS - 1);
            r_state      <= ST_RUN;
            r_err        <= 1'b0;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            if (w_grant) begin
                r_out_data   <= w_win_data;
                r_out_ex     <= w_win_ex;
                r_out_sel    <= w_win;
                r_last_grant <= w_win;
            end
            if ((|w_ovf) || (|w_bad)) begin
                r_err <= 1'b1;
            end
            // Drain completion is judged on the values this edge will load.
            case (r_state)
                ST_RUN:   if (flush_req) r_state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!flush_req) begin
                        r_state <= ST_RUN;
                    end else if (!w_out_valid_nxt && (&w_full_nxt)) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT:  if (!flush_req) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_ex_type  = r_out_ex;
    assign out_sel      = r_out_sel;
    assign credit_avail = w_avail;
    assign flush_done   = (r_state == ST_HALT);
    assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vx_dispatch_sched.sv
// ============================================================================
// Module      : tb_vx_dispatch_sched
// Description : Self-checking bench for vx_dispatch_sched; directed scenarios
//               plus randomized traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_dispatch_sched;

    localparam int NUM_REQS = 4;
    localparam int DATAW    = 64;
    localparam int NUM_EX   = 5;
    localparam int EX_BITS  = 3;
    localparam int CREDITS  = 4;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQS-1:0]         req_valid;
    logic [NUM_REQS*EX_BITS-1:0] req_ex_type;
    logic [NUM_REQS*DATAW-1:0]   req_data;
    logic [NUM_REQS-1:0]         req_ready;
    logic                        out_valid;
    logic [EX_BITS-1:0]          out_ex_type;
    logic [1:0]                  out_sel;
    logic [DATAW-1:0]            out_data;
    logic                        out_ready;
    logic [NUM_EX-1:0]           cmpl_valid;
    logic [NUM_EX-1:0]           credit_avail;
    logic                        flush_req;
    logic                        flush_done;
    logic                        err;

    always #5 clk = ~clk;

    vx_dispatch_sched #(
        .NUM_REQS(NUM_REQS), .DATAW(DATAW), .NUM_EX(NUM_EX),
        .EX_BITS(EX_BITS), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ex_type(req_ex_type), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_ex_type(out_ex_type), .out_sel(out_sel),
        .out_data(out_data), .out_ready(out_ready),
        .cmpl_valid(cmpl_valid), .credit_avail(credit_avail),
        .flush_req(flush_req), .flush_done(flush_done), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state kept as plain integers (state 0=RUN 1=DRAIN 2=HALT)
    bit          m_out_valid;
    logic [63:0] m_out_data;
    int          m_ex, m_sel, m_last, m_state;
    int          m_credit [NUM_EX];
    bit          m_err;

    logic [NUM_REQS-1:0] s_ready;
    logic [NUM_EX-1:0]   s_avail;
    logic                s_done, s_err;
    logic [1:0]          s_sel;

    function automatic int ex_of(input int i);
        return int'(req_ex_type[i*EX_BITS +: EX_BITS]);
    endfunction

    task automatic model_reset();
        m_out_valid = 0; m_out_data = '0; m_ex = 0; m_sel = 0;
        m_last = NUM_REQS - 1; m_state = 0; m_err = 0;
        for (int u = 0; u < NUM_EX; u++) m_credit[u] = CREDITS;
    endtask

    task automatic step();
        int g;
        bit full;
        logic [NUM_REQS-1:0] exp_ready;
        logic [NUM_EX-1:0]   exp_avail;
        @(negedge clk);
        g = -1;
        if (reset && m_state == 0 && (!m_out_valid || out_ready)) begin
            for (int k = 1; k <= NUM_REQS; k++) begin
                int i, e;
                i = (m_last + k) % NUM_REQS;
                e = ex_of(i);
                if (g < 0 && req_valid[i] && e < NUM_EX && m_credit[e] > 0) g = i;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        for (int u = 0; u < NUM_EX; u++) exp_avail[u] = (m_credit[u] != 0);
        chk_val("req_ready",    req_ready,    exp_ready);
        chk_val("out_valid",    out_valid,    m_out_valid);
        chk_val("out_data",     out_data,     m_out_data);
        chk_val("out_ex_type",  out_ex_type,  m_ex);
        chk_val("out_sel",      out_sel,      m_sel);
        chk_val("credit_avail", credit_avail, exp_avail);
        chk_val("flush_done",   flush_done,   m_state == 2);
        chk_val("err",          err,          m_err);
        s_ready = req_ready; s_avail = credit_avail; s_done = flush_done;
        s_err = err; s_sel = out_sel;

        if (!reset) begin
            model_reset();
        end else begin
            for (int u = 0; u < NUM_EX; u++) begin
                bit dec, inc;
                dec = (g >= 0) && (ex_of(g) == u);
                inc = cmpl_valid[u];
                if (dec && !inc) m_credit[u]--;
                else if (inc && !dec) begin
                    if (m_credit[u] == CREDITS) m_err = 1;
                    else m_credit[u]++;
                end
            end
            for (int i = 0; i < NUM_REQS; i++)
                if (req_valid[i] && ex_of(i) >= NUM_EX) m_err = 1;
            if (g >= 0) begin
                m_out_valid = 1; m_out_data = req_data[g*DATAW +: DATAW];
                m_ex = ex_of(g); m_sel = g; m_last = g;
            end else if (out_ready) begin
                m_out_valid = 0;
            end
            full = 1;
            for (int u = 0; u < NUM_EX; u++) if (m_credit[u] != CREDITS) full = 0;
            case (m_state)
                0: if (flush_req) m_state = 1;
                1: if (!flush_req) m_state = 0; else if (!m_out_valid && full) m_state = 2;
                default: if (!flush_req) m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_REQS; i++) req_data[i*DATAW +: DATAW] = {$urandom, $urandom};
    endtask

    // Return every outstanding credit and let the output stage empty.
    task automatic settle();
        req_valid = '0; out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            bit full;
            full = !m_out_valid;
            cmpl_valid = '0;
            for (int u = 0; u < NUM_EX; u++)
                if (m_credit[u] < CREDITS) begin cmpl_valid[u] = 1'b1; full = 0; end
            if (full) break;
            step();
        end
        cmpl_valid = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; req_valid = '0; req_ex_type = '0; req_data = '0;
        out_ready = 1'b1; cmpl_valid = '0; flush_req = 1'b0;
        model_reset();
        repeat (2) step();
        reset = 1'b1;

        // Round-robin order with unit 0 credits recycled each cycle
        req_valid = '1; req_ex_type = '0;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            cmpl_valid = '0;
            if (m_credit[0] < CREDITS) cmpl_valid[0] = 1'b1;
            step();
            chk_val("rr_order", s_ready, 64'(1) << (k % 4));
            if (k > 0) chk_val("sel_follow", s_sel, (k - 1) % 4);
        end

        // Credit exhaustion on unit 2
        settle();
        req_valid = 4'b0010; req_ex_type = '0; req_ex_type[3 +: 3] = 3'd2;
        n = 0;
        repeat (6) begin rand_data(); step(); n += s_ready[1]; end
        chk_val("credit_grants", n, 4);
        chk_val("avail2_zero", s_avail[2], 0);
        chk_val("ready1_blocked", s_ready[1], 0);
        cmpl_valid = 5'b00100; step(); n += s_ready[1];
        cmpl_valid = '0;
        repeat (3) begin step(); n += s_ready[1]; end
        chk_val("one_more_grant", n, 5);

        // Simultaneous grant and completion on unit 3, then overflow
        settle();
        req_valid = 4'b0001; req_ex_type = '0; req_ex_type[0 +: 3] = 3'd3;
        n = 0;
        repeat (2) begin rand_data(); step(); n += s_ready[0]; end
        cmpl_valid = 5'b01000; step(); n += s_ready[0];
        cmpl_valid = '0;
        repeat (4) begin step(); n += s_ready[0]; end
        chk_val("same_cycle_credit", n, 5);
        chk_val("avail3_zero", s_avail[3], 0);
        settle();
        cmpl_valid = 5'b01000; step();
        chk_val("no_err_yet", s_err, 0);
        cmpl_valid = '0; step();
        chk_val("ovf_err", s_err, 1);

        // Flush with two unit-0 requests in flight
        settle();
        req_valid = 4'b0001; req_ex_type = '0;
        repeat (2) begin rand_data(); step(); end
        req_valid = '0; flush_req = 1'b1; step();
        req_valid = 4'b0011;
        repeat (3) begin step(); chk_val("drain_no_grant", s_ready, 0); end
        cmpl_valid = 5'b00001; step();
        chk_val("not_done_early", s_done, 0);
        step();
        cmpl_valid = '0; step();
        chk_val("flush_done_set", s_done, 1);
        flush_req = 1'b0; step();
        step();
        chk_val("resume_grant", s_ready != 0, 1);

        // Reset while a request is held and unit 0 has one credit left
        settle();
        req_valid = 4'b0100; req_ex_type = '0;
        repeat (3) begin rand_data(); step(); end
        reset = 1'b0; req_valid = '1; step();
        chk_val("ready_in_reset", s_ready, 0);
        reset = 1'b1; step();
        chk_val("post_reset_grant", s_ready, 1);
        chk_val("post_reset_err", s_err, 0);
        chk_val("post_reset_avail", s_avail, 5'h1f);

        // Backpressure: held output must not change, nothing granted
        out_ready = 1'b0;
        repeat (3) begin rand_data(); step(); chk_val("hold_no_ready", s_ready, 0); end
        out_ready = 1'b1; rand_data(); step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 49) == 0) flush_req = !flush_req;
            req_valid = NUM_REQS'($urandom);
            for (int i = 0; i < NUM_REQS; i++) begin
                if ($urandom_range(0, 63) == 0)
                    req_ex_type[i*EX_BITS +: EX_BITS] = EX_BITS'($urandom_range(NUM_EX, 7));
                else
                    req_ex_type[i*EX_BITS +: EX_BITS] = EX_BITS'($urandom_range(0, NUM_EX - 1));
            end
            rand_data();
            out_ready = ($urandom_range(0, 3) != 0);
            cmpl_valid = '0;
            for (int u = 0; u < NUM_EX; u++)
                if ((m_credit[u] < CREDITS && $urandom_range(0, 9) < 4) || $urandom_range(0, 499) == 0)
                    cmpl_valid[u] = 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
